if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the memory's pc input.
- Latches the returned 32-bit instruction word into the IF/ID pipeline register.
- Handles stall, branch redirect and halt-on-empty-word (an all-zero instruction word ends the program).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IM_DEPTH_LOG2, 4, log2 of instruction-memory word count; PC word index wraps modulo 2^IM_DEPTH_LOG2.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- im_ir  input  32  instruction word returned by instruction memory for the current pc (combinational read).
- stall  input  1  hold PC and IF/ID contents this cycle.
- branch_taken  input  1  redirect fetch to branch_target and squash IF/ID.
- branch_target  input  32  redirect byte address.
- pc  output  32  current fetch address to instruction memory.
- ifid_ir  output  32  latched instruction word (slot1 = [31:16], slot0 = [15:0]).
- ifid_pc  output  32  address the latched word was fetched from.
- ifid_pc4  output  32  ifid_pc + 4.
- ifid_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped on an all-zero word.
- fetch_count  output  CNT_W  number of valid words latched since reset.

Behaviour:
Reset (reset==0, asynchronous, no clock needed):
- pc=RESET_PC.
- ifid_ir=0, ifid_pc=0, ifid_pc4=0, ifid_valid=0.
- halted=0, fetch_count=0, state=RUN.
- Reset asserted mid-operation overrides everything immediately.
- Deassertion is sampled at the next posedge.

States:
- RUN: fetching.
- HALT: fetch stopped; halted=1 exactly while in HALT.

Address arithmetic:
- next_seq(pc): word index pc[IM_DEPTH_LOG2+1:2] increments modulo 2^IM_DEPTH_LOG2.
- Bits above the index and bits [1:0] are unchanged.
- With defaults: 0x3C -> 0x00.
- Redirect address: bits [1:0] of branch_target are forced to 0; upper bits are taken as given.
- ifid_pc4 is a plain 32-bit +4 (wraps at 2^32), independent of index wrap.

Per posedge, in priority order:
1. branch_taken=1 (any state, overrides stall):
   - pc <= {branch_target[31:2],2'b00}.
   - ifid_valid <= 0, ifid_ir <= 0; ifid_pc/ifid_pc4 hold.
   - state <= RUN; fetch_count unchanged.
2. stall=1:
   - pc, IF/ID registers, state and fetch_count all hold.
3. state=HALT:
   - pc holds; ifid_valid <= 0; ifid_ir holds.
4. RUN and im_ir==0:
   - state <= HALT; ifid_valid <= 0; ifid_ir <= 0.
   - pc holds at the zero word's address; fetch_count unchanged.
5. RUN normal:
   - ifid_ir <= im_ir, ifid_pc <= pc, ifid_pc4 <= pc+4, ifid_valid <= 1.
   - pc <= next_seq(pc).
   - fetch_count <= fetch_count+1, saturating at all-ones.

Timing and flow:
- Latency: an instruction at pc appears on ifid_ir one posedge after pc is driven, if not stalled.
- IM writes (its negedge) are not observed by this block until the following posedge read.
- Outputs are registered only; no combinational path from inputs to outputs except pc -> IM -> im_ir -> ifid_ir D-input.

Test Plan:
- Reset low, IM words 0..2 = 0x11111111, 0x22222222, 0x33333333, word3 = 0; release reset -> ifid_ir 0x11111111/0x22222222/0x33333333 with ifid_pc 0/4/8 on successive edges, then halted=1, pc=0x0C, ifid_valid=0, fetch_count=3.
- In HALT, pulse branch_taken with branch_target=0x07 -> pc=0x04, halted=0, ifid_valid=0 that cycle, next edge ifid_ir=0x22222222, ifid_pc=0x04.
- Stall held 3 cycles while pc=0x08 -> pc, ifid_ir, ifid_valid and fetch_count unchanged throughout; release -> fetch resumes with 0x33333333.
- branch_taken and stall asserted together, target 0x20 -> pc=0x20, ifid_valid=0 (branch wins).
- All 16 words nonzero, run 17 fetches -> pc sequence 0x00..0x3C then 0x00, ifid_pc4 for word 15 = 0x40, fetch_count=17.
- Drop reset to 0 asynchronously between clock edges mid-run -> all outputs at reset values before the next posedge.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the instruction memory combinationally
// and latches the fetched word into the IF/ID register; stops on an all-zero word.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_RUN  | fetching sequential words each unstalled edge
//   ST_HALT | all-zero word seen; PC frozen until a redirect
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          IM_DEPTH_LOG2 = 4,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      im_ir,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_ir,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [IM_DEPTH_LOG2-1:0] IDX_ONE = {{(IM_DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]         CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]  state;
  logic [31:0] pc_seq;
  logic        unused_target_bits;

  // Only the word index advances; bits above it and the byte offset are left alone.
  always_comb begin
    pc_seq = pc;
    pc_seq[IM_DEPTH_LOG2+1:2] = pc[IM_DEPTH_LOG2+1:2] + IDX_ONE;
  end

  assign unused_target_bits = ^branch_target[1:0];
  assign halted = (state == ST_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      ifid_ir     <= 32'd0;
      ifid_pc     <= 32'd0;
      ifid_pc4    <= 32'd0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
      state       <= ST_RUN;
    end else if (branch_taken) begin
      // Redirect wins over stall and also leaves HALT.
      pc         <= {branch_target[31:2], 2'b00};
      ifid_valid <= 1'b0;
      ifid_ir    <= 32'd0;
      state      <= ST_RUN;
    end else if (!stall) begin
      if (state == ST_HALT) begin
        ifid_valid <= 1'b0;
      end else if (im_ir == 32'd0) begin
        state      <= ST_HALT;
        ifid_valid <= 1'b0;
        ifid_ir    <= 32'd0;
      end else begin
        ifid_ir    <= im_ir;
        ifid_pc    <= pc;
        ifid_pc4   <= pc + 32'd4;
        ifid_valid <= 1'b1;
        pc         <= pc_seq;
        if (fetch_count != '1) fetch_count <= fetch_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a 16-word combinational instruction memory model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] im_ir;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [16];
  int checks   = 0;
  int failures = 0;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .im_ir(im_ir), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .ifid_ir(ifid_ir), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign im_ir = mem[pc[5:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
    #2;
    checks++;
    if (pc !== 32'd0 || ifid_ir !== 32'd0 || ifid_pc !== 32'd0 || ifid_pc4 !== 32'd0 ||
        ifid_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state pc=%h ir=%h ifpc=%h pc4=%h v=%b h=%b cnt=%0d (want all zero)",
               pc, ifid_ir, ifid_pc, ifid_pc4, ifid_valid, halted, fetch_count);
    end
    reset = 1'b1;
  endtask

  task automatic test_sequential_halt();
    logic [31:0] exp_ir [3];
    exp_ir[0] = 32'h1111_1111; exp_ir[1] = 32'h2222_2222; exp_ir[2] = 32'h3333_3333;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ifid_ir !== exp_ir[k] || ifid_pc !== 32'(4*k) || ifid_pc4 !== 32'(4*k+4) ||
          ifid_valid !== 1'b1 || pc !== 32'(4*k+4) || fetch_count !== 16'(k+1)) begin
        failures++;
        $display("FAIL seq_fetch%0d ir=%h ifpc=%h pc4=%h v=%b pc=%h cnt=%0d want ir=%h ifpc=%h pc=%h cnt=%0d",
                 k, ifid_ir, ifid_pc, ifid_pc4, ifid_valid, pc, fetch_count,
                 exp_ir[k], 32'(4*k), 32'(4*k+4), k+1);
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 32'h0C || ifid_valid !== 1'b0 || fetch_count !== 16'd3 ||
        ifid_ir !== 32'd0 || ifid_pc !== 32'h08) begin
      failures++;
      $display("FAIL halt_entry h=%b pc=%h v=%b cnt=%0d ir=%h ifpc=%h want h=1 pc=0c v=0 cnt=3 ir=0 ifpc=08",
               halted, pc, ifid_valid, fetch_count, ifid_ir, ifid_pc);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 32'h0C || ifid_valid !== 1'b0 || fetch_count !== 16'd3) begin
      failures++;
      $display("FAIL halt_hold h=%b pc=%h v=%b cnt=%0d want h=1 pc=0c v=0 cnt=3",
               halted, pc, ifid_valid, fetch_count);
    end
  endtask

  task automatic test_branch_from_halt();
    branch_taken = 1'b1; branch_target = 32'h07;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (pc !== 32'h04 || halted !== 1'b0 || ifid_valid !== 1'b0 || ifid_ir !== 32'd0 ||
        ifid_pc !== 32'h08 || fetch_count !== 16'd3) begin
      failures++;
      $display("FAIL branch_redirect pc=%h h=%b v=%b ir=%h ifpc=%h cnt=%0d want pc=04 h=0 v=0 ir=0 ifpc=08 cnt=3",
               pc, halted, ifid_valid, ifid_ir, ifid_pc, fetch_count);
    end
    tick();
    checks++;
    if (ifid_ir !== 32'h2222_2222 || ifid_pc !== 32'h04 || ifid_valid !== 1'b1 ||
        pc !== 32'h08 || fetch_count !== 16'd4) begin
      failures++;
      $display("FAIL branch_refetch ir=%h ifpc=%h v=%b pc=%h cnt=%0d want ir=22222222 ifpc=04 v=1 pc=08 cnt=4",
               ifid_ir, ifid_pc, ifid_valid, pc, fetch_count);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (pc !== 32'h08 || ifid_ir !== 32'h2222_2222 || ifid_valid !== 1'b1 || fetch_count !== 16'd4) begin
        failures++;
        $display("FAIL stall_hold%0d pc=%h ir=%h v=%b cnt=%0d want pc=08 ir=22222222 v=1 cnt=4",
                 k, pc, ifid_ir, ifid_valid, fetch_count);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (ifid_ir !== 32'h3333_3333 || ifid_pc !== 32'h08 || pc !== 32'h0C || fetch_count !== 16'd5) begin
      failures++;
      $display("FAIL stall_release ir=%h ifpc=%h pc=%h cnt=%0d want ir=33333333 ifpc=08 pc=0c cnt=5",
               ifid_ir, ifid_pc, pc, fetch_count);
    end
  endtask

  task automatic test_branch_over_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    checks++;
    if (pc !== 32'h20 || ifid_valid !== 1'b0 || ifid_ir !== 32'd0 || fetch_count !== 16'd5) begin
      failures++;
      $display("FAIL branch_over_stall pc=%h v=%b ir=%h cnt=%0d want pc=20 v=0 ir=0 cnt=5",
               pc, ifid_valid, ifid_ir, fetch_count);
    end
  endtask

  task automatic test_wrap();
    #2 reset = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i) + 32'd1;
    #1 reset = 1'b1;
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (pc !== 32'(4*(k % 16))) begin
        failures++;
        $display("FAIL wrap_pc%0d pc=%h want %h", k, pc, 32'(4*(k % 16)));
      end
      tick();
      checks++;
      if (ifid_pc !== 32'(4*(k % 16)) || ifid_pc4 !== 32'(4*(k % 16) + 4) ||
          ifid_ir !== 32'hC0DE_0000 + 32'(k % 16) + 32'd1 || ifid_valid !== 1'b1 ||
          fetch_count !== 16'(k+1)) begin
        failures++;
        $display("FAIL wrap_fetch%0d ifpc=%h pc4=%h ir=%h v=%b cnt=%0d want ifpc=%h pc4=%h cnt=%0d",
                 k, ifid_pc, ifid_pc4, ifid_ir, ifid_valid, fetch_count,
                 32'(4*(k % 16)), 32'(4*(k % 16) + 4), k+1);
      end
    end
    checks++;
    if (pc !== 32'h04 || fetch_count !== 16'd17) begin
      failures++;
      $display("FAIL wrap_final pc=%h cnt=%0d want pc=04 cnt=17", pc, fetch_count);
    end
  endtask

  task automatic test_async_reset();
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd0 || ifid_ir !== 32'd0 || ifid_pc !== 32'd0 || ifid_pc4 !== 32'd0 ||
        ifid_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset pc=%h ir=%h ifpc=%h pc4=%h v=%b h=%b cnt=%0d (want all zero)",
               pc, ifid_ir, ifid_pc, ifid_pc4, ifid_valid, halted, fetch_count);
    end
    tick();
    checks++;
    if (pc !== 32'd0 || ifid_valid !== 1'b0 || fetch_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_held pc=%h v=%b cnt=%0d want pc=0 v=0 cnt=0", pc, ifid_valid, fetch_count);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential_halt();
    test_branch_from_halt();
    test_stall();
    test_branch_over_stall();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
